// File: rtl/pulled_bus_rx.sv
// pulled_bus_rx: receive end of a resistively pulled tristate bus.
//
// The net floats to IDLE_VAL through its pull whenever no driver is enabled.
// The resolved level is brought into the clock domain by a 2-flop
// synchroniser, then glitch-filtered. Each accepted level change goes out as
// one word on a depth-1 valid/ready output register.
//
// Parameters:
//   WIDTH          bus width (>= 1)
//   IDLE_VAL       level the net resolves to when undriven (pull value)
//   FILTER_CYCLES  consecutive equal synced samples needed to accept a level (1..255)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus_in      resolved bus level, asynchronous to clk
//   rx_data     accepted word
//   rx_valid    rx_data valid, held until rx_ready
//   rx_ready    consumer accepts the word when rx_valid & rx_ready
//   rx_overrun  one-cycle pulse: an accepted word was dropped because the output was full
//   rx_level    current accepted (filtered) level
//   rx_busy     1 whenever the filter is not in its idle state
//   rx_idle     (RX_IDLE_EVT_EN only) 1 when the held word equals IDLE_VAL
//
// Optional feature macro: RX_IDLE_EVT_EN. When defined, a return to IDLE_VAL
// is reported as a word and the rx_idle output exists. When undefined, a
// return to idle only updates rx_level.

module pulled_bus_rx #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] IDLE_VAL      = {WIDTH{1'b1}},
  parameter int unsigned      FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic [WIDTH-1:0] rx_level,
  output logic             rx_busy
`ifdef RX_IDLE_EVT_EN
  ,
  output logic             rx_idle
`endif
);

  localparam logic [8:0] FcLimit = 9'(FILTER_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StSettle
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] accepted_q;
  logic [WIDTH-1:0] cand_q;
  logic [7:0]       cnt_q;
  logic [8:0]       cnt_inc;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;

  logic             level_chg;
  logic [WIDTH-1:0] new_level;
  logic             word_evt;

  // Two-flop synchroniser; everything downstream looks only at sync2_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_VAL;
      sync2_q <= IDLE_VAL;
    end else begin
      sync1_q <= bus_in;
      sync2_q <= sync1_q;
    end
  end

  // Decode whether this edge accepts a genuinely new level. The count
  // compares against the incremented value so the accept lands exactly
  // FILTER_CYCLES edges after the level first appears in sync2_q.
  always_comb begin
    cnt_inc   = {1'b0, cnt_q} + 9'd1;
    level_chg = 1'b0;
    new_level = accepted_q;
    case (state_q)
      StIdle, StActive: begin
        if ((sync2_q != accepted_q) && (FILTER_CYCLES == 1)) begin
          level_chg = 1'b1;
          new_level = sync2_q;
        end
      end
      StSettle: begin
        // A candidate that settles back to the accepted level is a cancelled glitch.
        if ((sync2_q == cand_q) && (cnt_inc >= FcLimit) && (cand_q != accepted_q)) begin
          level_chg = 1'b1;
          new_level = cand_q;
        end
      end
      default: ;
    endcase
`ifdef RX_IDLE_EVT_EN
    word_evt = level_chg;
`else
    word_evt = level_chg && (new_level != IDLE_VAL);
`endif
  end

  // Filter FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      accepted_q <= IDLE_VAL;
      cand_q     <= IDLE_VAL;
      cnt_q      <= 8'd0;
    end else begin
      case (state_q)
        StIdle, StActive: begin
          if (sync2_q != accepted_q) begin
            cand_q <= sync2_q;
            cnt_q  <= 8'd1;
            if (FILTER_CYCLES == 1) begin
              accepted_q <= sync2_q;
              state_q    <= (sync2_q == IDLE_VAL) ? StIdle : StActive;
            end else begin
              state_q <= StSettle;
            end
          end
        end
        StSettle: begin
          if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= 8'd1;
          end else if (cnt_inc >= FcLimit) begin
            // On a cancelled glitch cand_q already equals accepted_q.
            accepted_q <= cand_q;
            cnt_q      <= 8'd0;
            state_q    <= (cand_q == IDLE_VAL) ? StIdle : StActive;
          end else begin
            cnt_q <= cnt_inc[7:0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Depth-1 output register. A word accepted while the consumer is taking the
  // previous one replaces it with no bubble; otherwise a full register drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (word_evt) begin
        if (!valid_q || rx_ready) begin
          data_q  <= new_level;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef RX_IDLE_EVT_EN
  logic idle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= 1'b0;
    end else if (word_evt && (!valid_q || rx_ready)) begin
      idle_q <= (new_level == IDLE_VAL);
    end
  end

  assign rx_idle = idle_q;
`endif

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_overrun = overrun_q;
  assign rx_level   = accepted_q;
  assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_pulled_bus_rx.sv
// Bench for pulled_bus_rx (WIDTH=8, IDLE_VAL=8'hFF, FILTER_CYCLES=4).
// Inputs change 1 time unit after a rising edge; a negedge monitor records
// consumed words and overrun pulses; state checks are taken after the edge.

module tb_pulled_bus_rx;

  localparam logic [7:0] Pull = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;
  logic [7:0] bus_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;
  logic [7:0] rx_level;
  logic       rx_busy;
`ifdef RX_IDLE_EVT_EN
  logic       rx_idle;
`endif

  // Net resolution: an enabled driver overrides the weak pull.
  assign bus_in = drv_en ? drv_val : Pull;

  pulled_bus_rx #(
    .WIDTH        (8),
    .IDLE_VAL     (8'hFF),
    .FILTER_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_overrun(rx_overrun),
    .rx_level  (rx_level),
    .rx_busy   (rx_busy)
`ifdef RX_IDLE_EVT_EN
    ,
    .rx_idle   (rx_idle)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got_q[$];
  int         ovr_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_overrun) ovr_cnt++;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v);
    if (v == Pull) begin
      drv_en = 1'b0;
    end else begin
      drv_en  = 1'b1;
      drv_val = v;
    end
  endtask

  typedef struct {
    logic [7:0] bus;
    int         cycles;
    logic       ready;
    int         exp_words;
    logic [7:0] exp_last;
    int         exp_ovr;
    logic [7:0] exp_level;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] bus, input int cycles, input logic ready,
                              input int words, input logic [7:0] last, input int ovr,
                              input logic [7:0] level, input logic valid,
                              input logic [7:0] data, input logic busy);
    vec_t v;
    v.bus = bus; v.cycles = cycles; v.ready = ready; v.exp_words = words;
    v.exp_last = last; v.exp_ovr = ovr; v.exp_level = level; v.exp_valid = valid;
    v.exp_data = data; v.exp_busy = busy;
    return v;
  endfunction

  localparam int NumVec = 15;
  vec_t vecs[NumVec];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         base_w;
    int         base_o;
    vec_t       t;

    //          bus    cyc rdy  wrd last   ovr level  vld  data   busy
    vecs[0]  = mk(8'hFF, 10, 1'b1, 0, 8'h00, 0, 8'hFF, 1'b0, 8'h00, 1'b0); // silent return to idle
    vecs[1]  = mk(8'h00,  3, 1'b1, 0, 8'h00, 0, 8'hFF, 1'b0, 8'h00, 1'b1); // 3-cycle glitch...
    vecs[2]  = mk(8'hFF, 10, 1'b1, 0, 8'h00, 0, 8'hFF, 1'b0, 8'h00, 1'b0); // ...is cancelled
    vecs[3]  = mk(8'h3C, 10, 1'b1, 1, 8'h3C, 0, 8'h3C, 1'b0, 8'h00, 1'b1);
    vecs[4]  = mk(8'hC3, 10, 1'b1, 1, 8'hC3, 0, 8'hC3, 1'b0, 8'h00, 1'b1);
    vecs[5]  = mk(8'h00, 10, 1'b1, 1, 8'h00, 0, 8'h00, 1'b0, 8'h00, 1'b1);
    vecs[6]  = mk(8'hFF, 10, 1'b1, 0, 8'h00, 0, 8'hFF, 1'b0, 8'h00, 1'b0);
    vecs[7]  = mk(8'h01, 10, 1'b0, 0, 8'h00, 0, 8'h01, 1'b1, 8'h01, 1'b1); // held, not consumed
    vecs[8]  = mk(8'h02, 10, 1'b0, 0, 8'h00, 1, 8'h02, 1'b1, 8'h01, 1'b1); // overrun, 01 kept
    vecs[9]  = mk(8'h02,  3, 1'b1, 1, 8'h01, 0, 8'h02, 1'b0, 8'h00, 1'b1); // drain 01
    vecs[10] = mk(8'hFF, 10, 1'b1, 0, 8'h00, 0, 8'hFF, 1'b0, 8'h00, 1'b0);
    vecs[11] = mk(8'h11, 10, 1'b0, 0, 8'h00, 0, 8'h11, 1'b1, 8'h11, 1'b1);
    vecs[12] = mk(8'h22,  5, 1'b0, 0, 8'h00, 0, 8'h11, 1'b1, 8'h11, 1'b1); // 22 still settling
    vecs[13] = mk(8'h22,  5, 1'b1, 2, 8'h22, 0, 8'h22, 1'b0, 8'h00, 1'b1); // take 11 as 22 lands
    vecs[14] = mk(8'hFF, 10, 1'b1, 0, 8'h00, 0, 8'hFF, 1'b0, 8'h00, 1'b0);

    // T1: reset values, then idle bus for 20 cycles.
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("reset rx_valid", int'(rx_valid), 0);
    chk("reset rx_data", int'(rx_data), 0);
    chk("reset rx_overrun", int'(rx_overrun), 0);
    chk("reset rx_level", int'(rx_level), 8'hFF);
    chk("reset rx_busy", int'(rx_busy), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("idle c%0d rx_valid", c), int'(rx_valid), 0);
      chk($sformatf("idle c%0d rx_level", c), int'(rx_level), 8'hFF);
      chk($sformatf("idle c%0d rx_busy", c), int'(rx_busy), 0);
    end

    // T2: latency of FF->5A is 6 edges from the change, valid for one cycle.
    rx_ready = 1'b1;
    base_w = got_q.size();
    drive(8'h5A);
    repeat (5) step();
    chk("t2 edge5 rx_valid", int'(rx_valid), 0);
    chk("t2 edge5 rx_busy", int'(rx_busy), 1);
    step();
    chk("t2 edge6 rx_valid", int'(rx_valid), 1);
    chk("t2 edge6 rx_data", int'(rx_data), 8'h5A);
    chk("t2 edge6 rx_level", int'(rx_level), 8'h5A);
    step();
    chk("t2 edge7 rx_valid", int'(rx_valid), 0);
    chk("t2 edge7 rx_data hold", int'(rx_data), 8'h5A);
    chk("t2 words", got_q.size() - base_w, 1);

    // Table: glitch rejection, several words, overrun, back-to-back handoff.
    for (int v = 0; v < NumVec; v++) begin
      t = vecs[v];
      base_w = got_q.size();
      base_o = ovr_cnt;
      drive(t.bus);
      rx_ready = t.ready;
      repeat (t.cycles) step();
      chk($sformatf("v%0d words", v), got_q.size() - base_w, t.exp_words);
      chk($sformatf("v%0d overrun", v), ovr_cnt - base_o, t.exp_ovr);
      chk($sformatf("v%0d rx_level", v), int'(rx_level), int'(t.exp_level));
      chk($sformatf("v%0d rx_valid", v), int'(rx_valid), int'(t.exp_valid));
      chk($sformatf("v%0d rx_busy", v), int'(rx_busy), int'(t.exp_busy));
      if (t.exp_words > 0 && got_q.size() > base_w)
        chk($sformatf("v%0d last word", v), int'(got_q[$]), int'(t.exp_last));
      if (t.exp_valid)
        chk($sformatf("v%0d rx_data", v), int'(rx_data), int'(t.exp_data));
    end

    // T5: sweep every value through the driver; FF is the pull level and is silent.
    rx_ready = 1'b1;
    drive(8'hFF);
    repeat (12) step();
    for (int i = 0; i < 256; i++) begin
      base_w  = got_q.size();
      drv_en  = 1'b1;
      drv_val = 8'(i);
      repeat (12) step();
      chk($sformatf("sweep %0d count", i), got_q.size() - base_w, (i == 255) ? 0 : 1);
      if (got_q.size() > base_w)
        chk($sformatf("sweep %0d word", i), int'(got_q[base_w]), i);
    end
    drv_en = 1'b0;
    repeat (12) step();

    // T6: asynchronous reset while 33 is settling and a word is held.
    rx_ready = 1'b0;
    drive(8'h44);
    repeat (10) step();
    chk("t6 pre rx_data", int'(rx_data), 8'h44);
    chk("t6 pre rx_valid", int'(rx_valid), 1);
    drive(8'h33);
    repeat (3) step();
    chk("t6 settling rx_busy", int'(rx_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async rx_valid", int'(rx_valid), 0);
    chk("t6 async rx_data", int'(rx_data), 0);
    chk("t6 async rx_overrun", int'(rx_overrun), 0);
    chk("t6 async rx_level", int'(rx_level), 8'hFF);
    chk("t6 async rx_busy", int'(rx_busy), 0);
    drive(8'hFF);
    repeat (3) step();
    rst_n = 1'b1;
    rx_ready = 1'b1;
    base_w = got_q.size();
    repeat (12) step();
    chk("t6 post words", got_q.size() - base_w, 0);
    chk("t6 post rx_valid", int'(rx_valid), 0);
    chk("t6 post rx_level", int'(rx_level), 8'hFF);
    chk("t6 post rx_busy", int'(rx_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
